sb_dsp_dma: RTL and testbench



---
 rtl/sb_dsp_dma.sv | 246 ++++++++++++++++++++++++
 tb/tb_sb_dsp_dma.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sb_dsp_dma.sv
// Sound Blaster DSP port block, command parser and 8-bit DMA playback engine.
// ISA strobes are resynchronised to sclk and acted on at their detected edges.
module sb_dsp_dma #(
    parameter logic [9:0]  BASE_ADDR = 10'h220,
    parameter int unsigned LEN_W     = 16,
    parameter int unsigned TC_SCALE  = 66,
    parameter int unsigned PER_W     = 24,
    parameter int unsigned CHANNELS  = 1
) (
    input  logic        sclk,
    input  logic        rst,
    input  logic [9:0]  io_addr,
    input  logic        aen,
    input  logic        iow_n,
    input  logic        ior_n,
    input  logic        dack_n,
    input  logic [7:0]  io_din,
    output logic [7:0]  io_dout,
    output logic        io_oe,
    output logic        drq,
    output logic        irq,
    output logic [15:0] sample_l,
    output logic [15:0] sample_r,
    output logic        sample_stb
);
    localparam int unsigned REM_W  = LEN_W + 1;
    localparam int unsigned FIFO_D = 4;
    localparam logic [9:0] ADDR_RST   = BASE_ADDR + 10'h006;
    localparam logic [9:0] ADDR_DATA  = BASE_ADDR + 10'h00A;
    localparam logic [9:0] ADDR_CMD   = BASE_ADDR + 10'h00C;
    localparam logic [9:0] ADDR_RSTAT = BASE_ADDR + 10'h00E;

    typedef enum logic [1:0] {ST_IDLE, ST_P1, ST_P2} cmd_state_t;
    typedef enum logic [1:0] {RD_NONE, RD_DATA, RD_STAT, RD_RSTAT} rd_sel_t;

    logic [2:0]       iow_q, ior_q, dack_q;
    logic             iow_rise, ior_fall, ior_rise, dack_act, io_wr, dma_wr;
    logic [PER_W-1:0] period;
    logic [15:0]      byte_smp;

    cmd_state_t       cmd_st;
    rd_sel_t          rd_sel;
    logic [7:0]       opcode, param_lo, tc;
    logic [LEN_W-1:0] blksize;
    logic [REM_W-1:0] remaining;
    logic             running, paused, auto_mode, exit_pend, phase;
    logic [PER_W-1:0] counter;
    logic [15:0]      pend_l;
    logic [7:0]       fifo [FIFO_D];
    logic [1:0]       rd_ptr, wr_ptr;
    logic [2:0]       fifo_cnt;

    assign iow_rise = iow_q[1] & ~iow_q[2];
    assign ior_fall = ~ior_q[1] & ior_q[2];
    assign ior_rise = ior_q[1] & ~ior_q[2];
    assign dack_act = ~dack_q[1];
    assign dma_wr   = iow_rise & dack_act;
    assign io_wr    = iow_rise & ~dack_act & ~aen;
    assign period   = PER_W'(TC_SCALE) * PER_W'(9'd256 - {1'b0, tc});
    assign byte_smp = {io_din ^ 8'h80, 8'h00};

    always_ff @(posedge sclk) begin
        sample_stb <= 1'b0;
        if (rst) begin
            iow_q     <= 3'b111;
            ior_q     <= 3'b111;
            dack_q    <= 3'b111;
            io_dout   <= '0;
            io_oe     <= 1'b0;
            drq       <= 1'b0;
            irq       <= 1'b0;
            sample_l  <= '0;
            sample_r  <= '0;
            cmd_st    <= ST_IDLE;
            rd_sel    <= RD_NONE;
            opcode    <= '0;
            param_lo  <= '0;
            tc        <= '0;
            blksize   <= '0;
            remaining <= '0;
            running   <= 1'b0;
            paused    <= 1'b0;
            auto_mode <= 1'b0;
            exit_pend <= 1'b0;
            phase     <= 1'b0;
            counter   <= '0;
            pend_l    <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            fifo_cnt  <= '0;
            for (int unsigned i = 0; i < FIFO_D; i++) fifo[i] <= '0;
        end else begin
            iow_q  <= {iow_q[1:0], iow_n};
            ior_q  <= {ior_q[1:0], ior_n};
            dack_q <= {dack_q[1:0], dack_n};

            // Read cycle: data is latched at IOR fall, side effects happen at IOR rise
            if (ior_fall) begin
                io_oe   <= 1'b0;
                io_dout <= '0;
                rd_sel  <= RD_NONE;
                if (!aen) begin
                    if (io_addr == ADDR_DATA) begin
                        io_oe <= 1'b1; io_dout <= fifo[rd_ptr]; rd_sel <= RD_DATA;
                    end else if (io_addr == ADDR_CMD) begin
                        io_oe <= 1'b1; io_dout <= 8'h00; rd_sel <= RD_STAT;
                    end else if (io_addr == ADDR_RSTAT) begin
                        io_oe <= 1'b1; io_dout <= {fifo_cnt != 3'd0, 7'h7F}; rd_sel <= RD_RSTAT;
                    end
                end
            end
            if (ior_rise) begin
                io_oe  <= 1'b0;
                rd_sel <= RD_NONE;
                if (rd_sel == RD_DATA && fifo_cnt != 3'd0) begin
                    rd_ptr   <= rd_ptr + 2'd1;
                    fifo_cnt <= fifo_cnt - 3'd1;
                end
                if (rd_sel == RD_RSTAT) irq <= 1'b0;
            end

            // Sample pacing; the counter only runs while no request is outstanding
            if (running && !paused && !drq) begin
                if (counter >= period) begin
                    if (!dack_act) begin
                        drq     <= 1'b1;
                        counter <= '0;
                    end
                end else begin
                    counter <= counter + PER_W'(1);
                end
            end

            if (io_wr && io_addr == ADDR_RST) begin
                if (io_din[0]) begin
                    running   <= 1'b0;
                    paused    <= 1'b0;
                    exit_pend <= 1'b0;
                    drq       <= 1'b0;
                    irq       <= 1'b0;
                    remaining <= '0;
                    cmd_st    <= ST_IDLE;
                    rd_ptr    <= '0;
                    wr_ptr    <= '0;
                    fifo_cnt  <= '0;
                end else if (fifo_cnt < 3'd4) begin
                    fifo[wr_ptr] <= 8'hAA;
                    wr_ptr       <= wr_ptr + 2'd1;
                    fifo_cnt     <= fifo_cnt + 3'd1;
                end
            end else if (io_wr && io_addr == ADDR_CMD) begin
                case (cmd_st)
                    ST_IDLE: begin
                        case (io_din)
                            8'h10, 8'h14, 8'h40, 8'h48: begin
                                opcode <= io_din;
                                cmd_st <= ST_P1;
                            end
                            8'h1C: if (blksize != '0) begin
                                remaining <= REM_W'(blksize) + REM_W'(1);
                                auto_mode <= 1'b1;
                                exit_pend <= 1'b0;
                                running   <= 1'b1;
                                paused    <= 1'b0;
                                counter   <= '0;
                                drq       <= 1'b0;
                                phase     <= 1'b0;
                            end
                            8'hD0: begin paused <= 1'b1; drq <= 1'b0; end
                            8'hD4: paused <= 1'b0;
                            8'hDA: exit_pend <= 1'b1;
                            8'hE1: if (fifo_cnt <= 3'd2) begin
                                fifo[wr_ptr]         <= 8'h04;
                                fifo[wr_ptr + 2'd1]  <= 8'h05;
                                wr_ptr               <= wr_ptr + 2'd2;
                                fifo_cnt             <= fifo_cnt + 3'd2;
                            end
                            default: ;
                        endcase
                    end
                    ST_P1: begin
                        cmd_st <= ST_IDLE;
                        case (opcode)
                            8'h10: begin
                                sample_l   <= byte_smp;
                                sample_r   <= byte_smp;
                                sample_stb <= 1'b1;
                            end
                            8'h40: tc <= io_din;
                            default: begin
                                param_lo <= io_din;
                                cmd_st   <= ST_P2;
                            end
                        endcase
                    end
                    default: begin
                        cmd_st <= ST_IDLE;
                        if (opcode == 8'h14) begin
                            remaining <= REM_W'({io_din, param_lo}) + REM_W'(1);
                            auto_mode <= 1'b0;
                            exit_pend <= 1'b0;
                            running   <= 1'b1;
                            paused    <= 1'b0;
                            counter   <= '0;
                            drq       <= 1'b0;
                            phase     <= 1'b0;
                        end else begin
                            blksize <= LEN_W'({io_din, param_lo});
                        end
                    end
                endcase
            end

            // DMA byte: DACK-qualified IOW, ignored when no transfer is active
            if (dma_wr && running && remaining != '0) begin
                drq     <= 1'b0;
                counter <= '0;
                if (CHANNELS == 2) begin
                    phase <= ~phase;
                    if (!phase) begin
                        pend_l <= byte_smp;
                    end else begin
                        sample_l   <= pend_l;
                        sample_r   <= byte_smp;
                        sample_stb <= 1'b1;
                    end
                end else begin
                    sample_l   <= byte_smp;
                    sample_r   <= byte_smp;
                    sample_stb <= 1'b1;
                end
                if (remaining == REM_W'(1)) begin
                    irq <= 1'b1;
                    if (auto_mode && !exit_pend) begin
                        remaining <= REM_W'(blksize) + REM_W'(1);
                    end else begin
                        running   <= 1'b0;
                        remaining <= '0;
                    end
                end else begin
                    remaining <= remaining - REM_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_sb_dsp_dma.sv
// Scoreboarded bench for sb_dsp_dma: mono and stereo instances share one ISA bus.
module tb_sb_dsp_dma;
    logic        sclk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  io_addr = '0;
    logic        aen = 1'b0, iow_n = 1'b1, ior_n = 1'b1, dack_n = 1'b1;
    logic [7:0]  io_din = '0;
    logic [7:0]  io_dout, st_dout;
    logic        io_oe, drq, irq, sample_stb;
    logic        st_oe, st_drq, st_irq, st_stb;
    logic [15:0] sample_l, sample_r, st_l, st_r;

    int          checks = 0, errors = 0;
    int unsigned cyc = 0, t_drq = 0, t_prev = 0;
    logic [7:0]  rd_q [$];
    logic [31:0] smp_q [$];
    logic [31:0] st_q [$];
    logic        st_chk = 1'b0;
    logic        oe_prev = 1'b0;

    logic [7:0]  t2_b [4] = '{8'h80, 8'hFF, 8'h00, 8'h7F};
    logic [15:0] t2_s [4] = '{16'h0000, 16'h7F00, 16'h8000, 16'hFF00};
    logic [7:0]  t3_b [8] = '{8'h01, 8'h81, 8'hC0, 8'h40, 8'h55, 8'hAA, 8'h12, 8'hEE};
    logic [15:0] t3_s [8] = '{16'h8100, 16'h0100, 16'h4000, 16'hC000,
                              16'hD500, 16'h2A00, 16'h9200, 16'h6E00};

    sb_dsp_dma dut (
        .sclk(sclk), .rst(rst), .io_addr(io_addr), .aen(aen), .iow_n(iow_n),
        .ior_n(ior_n), .dack_n(dack_n), .io_din(io_din), .io_dout(io_dout),
        .io_oe(io_oe), .drq(drq), .irq(irq), .sample_l(sample_l),
        .sample_r(sample_r), .sample_stb(sample_stb)
    );

    sb_dsp_dma #(.CHANNELS(2)) dut_st (
        .sclk(sclk), .rst(rst), .io_addr(io_addr), .aen(aen), .iow_n(iow_n),
        .ior_n(ior_n), .dack_n(dack_n), .io_din(io_din), .io_dout(st_dout),
        .io_oe(st_oe), .drq(st_drq), .irq(st_irq), .sample_l(st_l),
        .sample_r(st_r), .sample_stb(st_stb)
    );

    always #5 sclk = ~sclk;
    always @(posedge sclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int unsigned v,
                               input int unsigned lo, input int unsigned hi);
        checks++;
        if (v < lo || v > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, v, lo, hi);
        end
    endtask

    // Monitor: pops expected read data and samples whenever the DUTs present them
    always @(negedge sclk) begin
        if (io_oe && !oe_prev) begin
            if (rd_q.size() == 0) check("rd_unexpected", 32'(io_dout), 32'hDEAD);
            else check("rd_data", 32'(io_dout), 32'(rd_q.pop_front()));
        end
        oe_prev = io_oe;
        if (sample_stb) begin
            if (smp_q.size() == 0) check("smp_unexpected", {sample_l, sample_r}, 32'hDEAD);
            else check("smp_mono", {sample_l, sample_r}, smp_q.pop_front());
        end
        if (st_stb && st_chk) begin
            if (st_q.size() == 0) check("st_unexpected", {st_l, st_r}, 32'hDEAD);
            else check("smp_stereo", {st_l, st_r}, st_q.pop_front());
        end
    end

    task automatic cyc_wait(input int n);
        repeat (n) @(negedge sclk);
    endtask

    task automatic io_write(input logic [9:0] a, input logic [7:0] d, input logic en_aen);
        @(negedge sclk);
        io_addr = a; io_din = d; aen = en_aen;
        cyc_wait(2); iow_n = 1'b0;
        cyc_wait(4); iow_n = 1'b1;
        cyc_wait(5); aen = 1'b0;
    endtask

    task automatic io_read(input logic [9:0] a, input logic [7:0] exp);
        @(negedge sclk);
        io_addr = a; aen = 1'b0;
        cyc_wait(2); rd_q.push_back(exp); ior_n = 1'b0;
        cyc_wait(5); ior_n = 1'b1;
        cyc_wait(5);
    endtask

    task automatic dma_byte(input logic [7:0] b, input logic [15:0] exp);
        @(negedge sclk);
        smp_q.push_back({exp, exp});
        dack_n = 1'b0;
        cyc_wait(3); io_din = b; aen = 1'b1; iow_n = 1'b0;
        cyc_wait(4); iow_n = 1'b1;
        cyc_wait(4); dack_n = 1'b1; aen = 1'b0;
        cyc_wait(2);
    endtask

    task automatic wait_drq(input string name, input int max_cyc);
        int n = 0;
        while (!drq && n < max_cyc) begin
            @(negedge sclk);
            n++;
        end
        check(name, 32'(drq), 32'd1);
        t_drq = cyc;
    endtask

    task automatic no_drq(input string name, input int n);
        logic seen = 1'b0;
        repeat (n) begin
            @(negedge sclk);
            if (drq) seen = 1'b1;
        end
        check(name, 32'(seen), 32'd0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Hard reset and DSP reset handshake
        cyc_wait(5);
        check("rst_oe", 32'(io_oe), 32'd0);
        check("rst_drq", 32'(drq), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_samples", {sample_l, sample_r}, 32'd0);
        check("rst_stb", 32'(sample_stb), 32'd0);
        rst = 1'b0;
        cyc_wait(3);
        io_write(10'h226, 8'h01, 1'b0);
        io_write(10'h226, 8'h00, 1'b0);
        io_read(10'h22E, 8'hFF);
        io_read(10'h22A, 8'hAA);
        io_read(10'h22E, 8'h7F);
        io_read(10'h22C, 8'h00);

        // Single-cycle DMA, TC=166 -> 5940-cycle period
        io_write(10'h22C, 8'h40, 1'b0);
        io_write(10'h22C, 8'hA6, 1'b0);
        io_write(10'h22C, 8'h14, 1'b0);
        io_write(10'h22C, 8'h03, 1'b0);
        io_write(10'h22C, 8'h00, 1'b0);
        t_prev = cyc;
        for (int i = 0; i < 4; i++) begin
            wait_drq("t2_drq", 7000);
            check_range("t2_period", t_drq - t_prev, 5930, 6000);
            t_prev = t_drq;
            if (i == 3) check("t2_irq_before_last", 32'(irq), 32'd0);
            dma_byte(t2_b[i], t2_s[i]);
        end
        check("t2_irq_end", 32'(irq), 32'd1);
        no_drq("t2_no_5th", 6500);
        io_read(10'h22E, 8'h7F);
        check("t2_irq_cleared", 32'(irq), 32'd0);

        // Auto-init with a 2-byte block, TC=255 -> 66-cycle period
        io_write(10'h22C, 8'h40, 1'b0);
        io_write(10'h22C, 8'hFF, 1'b0);
        io_write(10'h22C, 8'h1C, 1'b0);
        no_drq("t3_1c_blk0", 200);
        io_write(10'h22C, 8'h48, 1'b0);
        io_write(10'h22C, 8'h01, 1'b0);
        io_write(10'h22C, 8'h00, 1'b0);
        io_write(10'h22C, 8'h1C, 1'b0);
        for (int i = 0; i < 6; i++) begin
            wait_drq("t3_drq", 300);
            dma_byte(t3_b[i], t3_s[i]);
            check("t3_irq", 32'(irq), 32'(i % 2));
            if (i % 2 == 1) io_read(10'h22E, 8'h7F);
        end
        wait_drq("t3_drq7", 300);
        dma_byte(t3_b[6], t3_s[6]);
        io_write(10'h22C, 8'hDA, 1'b0);
        wait_drq("t3_drq8", 300);
        dma_byte(t3_b[7], t3_s[7]);
        check("t3_irq_exit", 32'(irq), 32'd1);
        no_drq("t3_stopped", 400);
        io_read(10'h22E, 8'h7F);

        // Pause / continue in a 4-byte single transfer
        io_write(10'h22C, 8'h14, 1'b0);
        io_write(10'h22C, 8'h03, 1'b0);
        io_write(10'h22C, 8'h00, 1'b0);
        wait_drq("t4_drq1", 300);
        dma_byte(8'h01, 16'h8100);
        io_write(10'h22C, 8'hD0, 1'b0);
        check("t4_pause_drq", 32'(drq), 32'd0);
        no_drq("t4_paused", 210);
        io_write(10'h22C, 8'hD4, 1'b0);
        wait_drq("t4_drq2", 300);
        dma_byte(8'h81, 16'h0100);
        wait_drq("t4_drq3", 300);
        dma_byte(8'hC0, 16'h4000);
        check("t4_irq_3rd", 32'(irq), 32'd0);
        wait_drq("t4_drq4", 300);
        dma_byte(8'h40, 16'hC000);
        check("t4_irq_4th", 32'(irq), 32'd1);
        io_read(10'h22E, 8'h7F);

        // Stereo pairing on the CHANNELS=2 instance
        st_chk = 1'b1;
        st_q.push_back({16'h1000, 16'hF000});
        io_write(10'h22C, 8'h14, 1'b0);
        io_write(10'h22C, 8'h01, 1'b0);
        io_write(10'h22C, 8'h00, 1'b0);
        wait_drq("t5_drq1", 300);
        dma_byte(8'h90, 16'h1000);
        wait_drq("t5_drq2", 300);
        dma_byte(8'h70, 16'hF000);
        cyc_wait(5);
        check("t5_st_left", 32'(st_q.size()), 32'd0);
        check("t5_irq", 32'(irq), 32'd1);
        st_chk = 1'b0;
        io_read(10'h22E, 8'h7F);

        // Version query, AEN qualification, direct DAC, full-length transfer
        io_write(10'h22C, 8'hE1, 1'b0);
        io_read(10'h22A, 8'h04);
        io_read(10'h22A, 8'h05);
        io_read(10'h22E, 8'h7F);
        io_write(10'h22C, 8'hE1, 1'b1);
        io_read(10'h22E, 8'h7F);
        smp_q.push_back({16'h4000, 16'h4000});
        io_write(10'h22C, 8'h10, 1'b0);
        io_write(10'h22C, 8'hC0, 1'b0);
        io_write(10'h22C, 8'h14, 1'b0);
        io_write(10'h22C, 8'hFF, 1'b0);
        io_write(10'h22C, 8'hFF, 1'b0);
        wait_drq("t6_drq1", 300);
        dma_byte(8'h33, 16'hB300);
        check("t6_irq_ffff", 32'(irq), 32'd0);
        wait_drq("t6_drq2", 300);
        io_write(10'h226, 8'h01, 1'b0);
        check("t6_srst_drq", 32'(drq), 32'd0);
        check("t6_hold_l", 32'(sample_l), 32'h0000B300);
        io_write(10'h226, 8'h00, 1'b0);
        io_read(10'h22E, 8'hFF);
        io_read(10'h22A, 8'hAA);
        no_drq("t6_aborted", 200);

        cyc_wait(10);
        check("rd_q_left", 32'(rd_q.size()), 32'd0);
        check("smp_q_left", 32'(smp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
